// File: rtl/johnson_pkg.sv
// Shared types and helpers for the Johnson sequencer.
// Code/phase helpers work on MAX_W-bit zero-padded vectors so that any WIDTH < MAX_W can use them.
package johnson_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;
  localparam int MAX_W     = 16;
  localparam int IDX_W     = $clog2(2 * MAX_W);

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } phase_t;

  // Shift right, feeding the inverted LSB into bit w-1.
  function automatic logic [MAX_W-1:0] johnson_next(input logic [MAX_W-1:0] code, input int w);
    logic [MAX_W-1:0] low_mask;
    logic [MAX_W-1:0] top_bit;
    low_mask = (MAX_W'(1) << (w - 1)) - MAX_W'(1);
    top_bit  = MAX_W'(1) << (w - 1);
    return ((code >> 1) & low_mask) | (code[0] ? '0 : top_bit);
  endfunction

  // Code at position k: k ones from the top for k <= w, then 2w-k ones at the bottom.
  function automatic logic [MAX_W-1:0] johnson_code(input int k, input int w);
    logic [MAX_W-1:0] full;
    logic [MAX_W-1:0] low;
    if (k <= w) begin
      full = (MAX_W'(1) << w) - MAX_W'(1);
      low  = (MAX_W'(1) << (w - k)) - MAX_W'(1);
      return full & ~low;
    end else begin
      return (MAX_W'(1) << (2 * w - k)) - MAX_W'(1);
    end
  endfunction

  function automatic phase_t johnson_phase(input logic [MAX_W-1:0] code, input int w);
    phase_t p;
    p = '0;
    for (int k = 0; k < 2 * MAX_W; k++) begin
      if ((k < 2 * w) && (code == johnson_code(k, w))) begin
        p.valid = 1'b1;
        p.idx   = IDX_W'(k);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/johnson_core.sv
// Johnson counter register with clear, enable and illegal-code self-correction.
// An illegal code loads zero on the next enabled step instead of shifting.
module johnson_core
  import johnson_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [MAX_W-1:0] code_wide;
  logic [MAX_W-1:0] next_wide;
  phase_t           ph;
  logic             unused_core;

  assign code_wide   = MAX_W'(count_q);
  assign next_wide   = johnson_next(code_wide, WIDTH);
  assign ph          = johnson_phase(code_wide, WIDTH);
  assign unused_core = ^{next_wide[MAX_W-1:WIDTH], ph.idx};

  always_comb begin
    count_d = '0;
    if (ph.valid) begin
      count_d = next_wide[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Run controller for a Johnson counter: start/busy/done handshake, hold and abort,
// remaining-step tracking and combinational phase decode of the counter value.
module johnson_seq_ctrl
  import johnson_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  localparam int PIDX_W = $clog2(2 * WIDTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [CNT_W-1:0]     step_count_i,
  input  logic                 hold_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [WIDTH-1:0]     count_o,
  output logic [PIDX_W-1:0]    phase_idx_o,
  output logic [2*WIDTH-1:0]   phase_strb_o,
  output logic                 illegal_flg_o
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic               illegal_q, illegal_d;
  logic               busy_q, done_q;
  logic               core_en, core_clr;
  logic [WIDTH-1:0]   core_count;
  logic [MAX_W-1:0]   code_wide;
  phase_t             ph;
  logic               unused_ctrl;

  johnson_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (core_en),
    .clr_i   (core_clr),
    .count_o (core_count)
  );

  assign code_wide   = MAX_W'(core_count);
  assign ph          = johnson_phase(code_wide, WIDTH);
  assign unused_ctrl = ^ph.idx[IDX_W-1:PIDX_W];

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    illegal_d   = illegal_q;
    core_en     = 1'b0;
    core_clr    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (step_count_i != '0) begin
            state_d     = RUN;
            remaining_d = step_count_i;
            illegal_d   = 1'b0;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d     = IDLE;
          remaining_d = '0;
          core_clr    = 1'b1;
        end else if (hold_i) begin
          state_d = PAUSE;
        end else begin
          core_en     = 1'b1;
          remaining_d = remaining_q - CNT_W'(1);
          // the core replaces an illegal code with zero on this step
          if (!ph.valid) begin
            illegal_d = 1'b1;
          end
          if (remaining_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      PAUSE: begin
        if (abort_i) begin
          state_d     = IDLE;
          remaining_d = '0;
          core_clr    = 1'b1;
        end else if (!hold_i) begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      illegal_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      illegal_q   <= illegal_d;
      busy_q      <= (state_d == RUN) || (state_d == PAUSE);
      done_q      <= (state_d == DONE);
    end
  end

  for (genvar gi = 0; gi < 2 * WIDTH; gi++) begin : g_strb
    assign phase_strb_o[gi] = ph.valid && (ph.idx == IDX_W'(gi));
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign count_o       = core_count;
  assign phase_idx_o   = ph.idx[PIDX_W-1:0];
  assign illegal_flg_o = illegal_q;

endmodule
